// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: oversamples TCK/TMS/TDI on i_clk, runs the 16-state TAP machine,
// and steers IR/BYPASS/IDCODE/BSR shifting with TDO updated on TCK falling edges.
module jtag_tap_ctrl #(
    parameter logic [31:0] P_IDCODE = 32'h5249_5343
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_jtagTCK,
    input  logic       i_jtagTMS,
    input  logic       i_jtagTDI,
    output logic       o_jtagTDO,
    output logic       o_bsrShiftIn,
    input  logic       i_bsrShiftOut,
    output logic       o_bsrDoShift,
    output logic       o_bsrCanDrive,
    output logic [3:0] o_tapState
);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tapState_t;

    localparam logic [3:0] IR_SAMPLE = 4'h1;
    localparam logic [3:0] IR_EXTEST = 4'h2;
    localparam logic [3:0] IR_IDCODE = 4'h3;

    tapState_t   state, nextState;
    logic [1:0]  tckSync, tmsSync, tdiSync;
    logic        tckHist;
    logic        tckRise, tckFall, tms, tdi;
    logic [3:0]  ir, irShift;
    logic [31:0] idShift;
    logic        bypassReg;
    logic        bsrSel;

    assign tckRise      = tckSync[1] & ~tckHist;
    assign tckFall      = ~tckSync[1] & tckHist;
    assign tms          = tmsSync[1];
    assign tdi          = tdiSync[1];
    assign bsrSel       = (ir == IR_SAMPLE) || (ir == IR_EXTEST);
    assign o_bsrShiftIn = tdi;
    assign o_tapState   = state;
    assign o_bsrDoShift = tckRise && (state == SH_DR) && bsrSel;

    always_comb begin
        nextState = state;
        case (state)
            TLR:      nextState = tms ? TLR    : RTI;
            RTI:      nextState = tms ? SEL_DR : RTI;
            SEL_DR:   nextState = tms ? SEL_IR : CAP_DR;
            CAP_DR:   nextState = tms ? EX1_DR : SH_DR;
            SH_DR:    nextState = tms ? EX1_DR : SH_DR;
            EX1_DR:   nextState = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: nextState = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   nextState = tms ? UPD_DR : SH_DR;
            UPD_DR:   nextState = tms ? SEL_DR : RTI;
            SEL_IR:   nextState = tms ? TLR    : CAP_IR;
            CAP_IR:   nextState = tms ? EX1_IR : SH_IR;
            SH_IR:    nextState = tms ? EX1_IR : SH_IR;
            EX1_IR:   nextState = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: nextState = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   nextState = tms ? UPD_IR : SH_IR;
            UPD_IR:   nextState = tms ? SEL_DR : RTI;
            default:  nextState = TLR;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tckSync       <= '0;
            tmsSync       <= '0;
            tdiSync       <= '0;
            tckHist       <= 1'b0;
            state         <= TLR;
            ir            <= IR_IDCODE;
            irShift       <= '0;
            idShift       <= '0;
            bypassReg     <= 1'b0;
            o_jtagTDO     <= 1'b0;
            o_bsrCanDrive <= 1'b0;
        end else begin
            tckSync       <= {tckSync[0], i_jtagTCK};
            tmsSync       <= {tmsSync[0], i_jtagTMS};
            tdiSync       <= {tdiSync[0], i_jtagTDI};
            tckHist       <= tckSync[1];
            o_bsrCanDrive <= (ir == IR_EXTEST) && (state != TLR);

            if (tckRise) begin
                state <= nextState;
                case (state)
                    CAP_IR: irShift <= 4'b0001;
                    SH_IR:  irShift <= {tdi, irShift[3:1]};
                    CAP_DR: begin
                        idShift   <= P_IDCODE;
                        bypassReg <= 1'b0;
                    end
                    SH_DR: begin
                        if (ir == IR_IDCODE)
                            idShift <= {tdi, idShift[31:1]};
                        else if (!bsrSel)
                            bypassReg <= tdi;
                    end
                    default: ;
                endcase
                // IR loads on entry to UpdIR; irShift is idle in Ex1IR/Ex2IR so it is final here
                if (nextState == UPD_IR)
                    ir <= irShift;
                else if (nextState == TLR)
                    ir <= IR_IDCODE;
            end

            if (tckFall) begin
                case (state)
                    SH_IR:   o_jtagTDO <= irShift[0];
                    SH_DR: begin
                        if (bsrSel)
                            o_jtagTDO <= i_bsrShiftOut;
                        else if (ir == IR_IDCODE)
                            o_jtagTDO <= idShift[0];
                        else
                            o_jtagTDO <= bypassReg;
                    end
                    default: o_jtagTDO <= 1'b0;
                endcase
            end
        end
    end

endmodule
